// File: rtl/hall_pulse_gen.sv
// Programmable Hall-sensor pulse-train generator: burst or continuous square wave.
// Optional macro HALL_BOUNCE_EN adds bounce_en, emulating edge bounce at each rise.
module hall_pulse_gen #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned HIGH_W   = 16,
  parameter int unsigned BURST_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [HIGH_W-1:0]   high_cycles,
  input  logic [BURST_W-1:0]  burst_len,
`ifdef HALL_BOUNCE_EN
  input  logic                bounce_en,
`endif
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic [BURST_W-1:0]  pulse_cnt
);

  localparam int unsigned CW = (PERIOD_W > HIGH_W) ? PERIOD_W : HIGH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       phase_q;
  logic [HIGH_W-1:0]   high_q;
  logic [PERIOD_W-1:0] low_q;
  logic [BURST_W-1:0]  burst_q;
  logic                bounce_q;
  logic                pulse_out_q;
  logic                busy_q;
  logic                done_q;
  logic [BURST_W-1:0]  pulse_cnt_q;

  logic [PERIOD_W-1:0] period_d;
  logic [HIGH_W-1:0]   high_raw_d;
  logic [HIGH_W-1:0]   high_d;
  logic [PERIOD_W-1:0] low_d;
  logic                bounce_d;
  logic [CW-1:0]       phase_nxt_c;

  // Clamped configuration, latched only when a start is accepted
  always_comb begin
    period_d   = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    high_raw_d = (high_cycles == '0) ? HIGH_W'(1) : high_cycles;
    if (CW'(high_raw_d) >= CW'(period_d)) begin
      high_d = HIGH_W'(period_d - PERIOD_W'(1));
    end else begin
      high_d = high_raw_d;
    end
    low_d = period_d - PERIOD_W'(high_d);
`ifdef HALL_BOUNCE_EN
    bounce_d = bounce_en && (high_d >= HIGH_W'(5));
`else
    bounce_d = 1'b0;
`endif
    phase_nxt_c = phase_q + CW'(1);
  end

  // Phase counter runs 1..H in HIGH and 1..(P-H) in LOW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      high_q      <= '0;
      low_q       <= '0;
      burst_q     <= '0;
      bounce_q    <= 1'b0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= HIGH;
            phase_q     <= CW'(1);
            high_q      <= high_d;
            low_q       <= low_d;
            burst_q     <= burst_len;
            bounce_q    <= bounce_d;
            pulse_out_q <= 1'b1;
            busy_q      <= 1'b1;
            pulse_cnt_q <= BURST_W'(1);
          end
        end
        HIGH: begin
          if (stop) begin
            state_q     <= IDLE;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (phase_q == CW'(high_q)) begin
            state_q     <= LOW;
            phase_q     <= CW'(1);
            pulse_out_q <= 1'b0;
          end else begin
            phase_q     <= phase_nxt_c;
            // Bounce drops the output on the 2nd and 4th high cycle
            pulse_out_q <= !(bounce_q && ((phase_nxt_c == CW'(2)) || (phase_nxt_c == CW'(4))));
          end
        end
        LOW: begin
          if (stop) begin
            state_q     <= IDLE;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (phase_q == CW'(low_q)) begin
            if ((burst_q == '0) || (pulse_cnt_q != burst_q)) begin
              state_q     <= HIGH;
              phase_q     <= CW'(1);
              pulse_out_q <= 1'b1;
              pulse_cnt_q <= pulse_cnt_q + BURST_W'(1);
            end else begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end else begin
            phase_q <= phase_nxt_c;
          end
        end
        default: begin
          state_q     <= IDLE;
          pulse_out_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
